ksadd_seq: RTL and testbench
============================

KSADD_SEQ -- requirements
Module: ksadd_seq

Interface
- REQ-001: Parameter NIB, default 4, number of 4-bit nibbles per operand. Legal range 2..8. Operand width W = 4*NIB.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-004: clr  input  1  synchronous abort; returns the block to IDLE.
- REQ-005: in_valid  input  1  operand request valid.
- REQ-006: in_ready  output  1  block can accept operands; high only in IDLE.
- REQ-007: a  input  W  operand A.
- REQ-008: b  input  W  operand B.
- REQ-009: cin  input  1  carry-in to nibble 0.
- REQ-010: out_valid  output  1  result valid; high only in DONE.
- REQ-011: out_ready  input  1  consumer accepts result.
- REQ-012: sum  output  W  registered result.
- REQ-013: cout  output  1  carry out of nibble NIB-1.
- REQ-014: busy  output  1  high in RUN or DONE.
- REQ-015: ovf  output  1  signed overflow; present only under KSSEQ_OVF_EN (REQ-032).

Function
- REQ-016: The block SHALL instantiate exactly one ksadd4b and time-share it, one nibble per RUN cycle, LSB nibble first.
- REQ-017: FSM states: IDLE, RUN, DONE. Encoding is free.
- REQ-018: IDLE -> RUN on in_valid && in_ready. a, b and cin are captured into internal registers, and nibble index idx is set to 0.
- REQ-019: RUN, each cycle: the adder sees k = a_reg[4*idx+:4], t = b_reg[4*idx+:4], cin = carry_reg. On the edge, s3..s0 are written to sum[4*idx+:4], s4 to carry_reg, and idx increments.
- REQ-020: RUN -> DONE on the edge that processes idx == NIB-1. cout takes that nibble's s4 on the same edge.
- REQ-021: Latency: out_valid SHALL rise exactly NIB cycles after the accepting edge.
- REQ-022: DONE -> IDLE on out_valid && out_ready. sum and cout SHALL stay stable while out_valid is high and out_ready is low.
- REQ-023: sum and cout SHALL keep their last values in IDLE until the next RUN overwrites them.
- REQ-024: in_valid is ignored outside IDLE. There is no input buffering, so a back-to-back issue costs NIB+1 cycles minimum.
- REQ-025: clr, in any state, SHALL force IDLE on the next edge. It clears idx and carry_reg and leaves sum and cout unchanged.
- REQ-026: clr takes priority over a simultaneous accept or output handshake. That transaction is dropped.
- REQ-027: Arithmetic is unsigned modulo 2^W plus carry: {cout, sum} = a + b + cin.

Reset
- REQ-028: rst_n low SHALL immediately force IDLE, regardless of clk.
- REQ-029: Reset values: in_ready = 1 (once in IDLE), out_valid = 0, busy = 0, sum = 0, cout = 0, ovf = 0, idx = 0, carry_reg = 0, and all operand registers = 0.
- REQ-030: Reset asserted mid-RUN or in DONE SHALL discard the operation. No out_valid pulse follows deassertion.
- REQ-031: The first accept is possible on the first rising edge after rst_n deassertion.

Configuration
- REQ-032: KSSEQ_OVF_EN defined: port ovf exists and is written on the RUN -> DONE edge as (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]). ovf is held with sum.
- REQ-033: KSSEQ_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

Verification (NIB = 4)
- REQ-034: a = 16'h1234, b = 16'h4321, cin = 0 -> sum = 16'h5555, cout = 0, out_valid exactly 4 cycles after accept.
- REQ-035: a = 16'hFFFF, b = 16'h0001, cin = 0 -> sum = 16'h0000, cout = 1 (carry ripples through all nibbles). Also a = 16'h0000, b = 16'h0000, cin = 1 -> sum = 16'h0001.
- REQ-036: With KSSEQ_OVF_EN: a = 16'h7FFF, b = 16'h0001 -> sum = 16'h8000, ovf = 1. With a = 16'h8000, b = 16'h8000 -> sum = 16'h0000, cout = 1, ovf = 1.
- REQ-037: Hold out_ready low for 3 cycles in DONE -> sum and out_valid stable, in_ready = 0, and a new in_valid is ignored. out_ready high -> IDLE on the next edge.
- REQ-038: Pulse clr at idx = 2 -> IDLE next cycle with no out_valid pulse. Then a = 16'h0F0F, b = 16'h00F1 -> sum = 16'h1000, cout = 0.
- REQ-039: Drop rst_n asynchronously mid-RUN -> outputs reach their reset values without a clock edge. After release, a fresh add completes correctly.

Source files
------------

// File: rtl/ksadd_seq.sv
// ksadd_seq: sequential W-bit adder that time-shares one 4-bit Kogge-Stone
// adder cell (ksadd4b), one nibble per cycle, LSB nibble first.
// Optional feature macro: KSSEQ_OVF_EN adds the signed-overflow output ovf.

// 4-bit Kogge-Stone adder cell: s[3:0] = sum nibble, s[4] = carry out.
module ksadd4b (
  input  logic [3:0] k,
  input  logic [3:0] t,
  input  logic       cin,
  output logic [4:0] s
);

  logic [3:0] p;
  logic [3:0] g0;
  logic [3:0] g1;
  logic [3:0] p1;
  logic [3:0] g2;
  logic [4:0] c;

  // Prefix tree: carry-in folded into bit 0 generate, then spans of 1 and 2.
  always_comb begin
    p     = k ^ t;
    g0    = k & t;
    g0[0] = (k[0] & t[0]) | (p[0] & cin);
    g1    = g0;
    p1    = p;
    for (int i = 1; i < 4; i++) begin
      g1[i] = g0[i] | (p[i] & g0[i-1]);
      p1[i] = p[i] & p[i-1];
    end
    g2 = g1;
    for (int i = 2; i < 4; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g2[i];
    end
    s = {c[4], p ^ c[3:0]};
  end

endmodule

module ksadd_seq #(
  parameter int unsigned NIB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NIB-1:0]  a,
  input  logic [4*NIB-1:0]  b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NIB-1:0]  sum,
  output logic              cout,
  output logic              busy
`ifdef KSSEQ_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int unsigned W     = 4 * NIB;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NIB-1:0][3:0]    a_q, a_d;
  logic [NIB-1:0][3:0]    b_q, b_d;
  logic [NIB-1:0][3:0]    sum_q, sum_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;

  logic [3:0]             nib_a;
  logic [3:0]             nib_b;
  logic [4:0]             nib_s;
  logic                   last_nib;

  // Current nibble slice fed to the shared adder cell.
  always_comb begin
    nib_a    = a_q[idx_q];
    nib_b    = b_q[idx_q];
    last_nib = (idx_q == IDX_W'(NIB - 1));
  end

  ksadd4b u_add (
    .k   (nib_a),
    .t   (nib_b),
    .cin (carry_q),
    .s   (nib_s)
  );

  // Next-state, datapath updates and registered status flags.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    if (clr) begin
      // Abort wins over any handshake in flight; results are left intact.
      state_d = ST_IDLE;
      idx_d   = '0;
      carry_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_RUN;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
          end
        end
        ST_RUN: begin
          sum_d[idx_q] = nib_s[3:0];
          carry_d      = nib_s[4];
          if (last_nib) begin
            state_d = ST_DONE;
            cout_d  = nib_s[4];
            idx_d   = '0;
            ovf_d   = (a_q[NIB-1][3] == b_q[NIB-1][3]) &&
                      (nib_s[3] != a_q[NIB-1][3]);
          end else begin
            idx_d = IDX_W'(idx_q + IDX_W'(1));
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = W'(sum_q);
  assign cout      = cout_q;

`ifdef KSSEQ_OVF_EN
  assign ovf = ovf_q;
`else
  // ovf_q only feeds the optional port; keep it observable to avoid dangling logic.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ksadd_seq.sv
// Self-checking bench for ksadd_seq (NIB = 4) against an arithmetic model.
module tb_ksadd_seq;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;
`ifdef KSSEQ_OVF_EN
  logic          ovf;
`endif

  int n_total;
  int n_bad;

  ksadd_seq #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef KSSEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition of the operands and carry-in.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Issue one add, check latency and result, optionally stall in DONE, then retire.
  task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input int hold, input string tag);
    logic [W:0]   exp;
    logic [W-1:0] held_sum;
    int           cnt;
    exp = ref_add(xa, xb, xc);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); cin = 1'($urandom());
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq({tag, "_latency"}, 32'(cnt), 32'(NIB));
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp[W]));
`ifdef KSSEQ_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(xa, xb, xc)));
`endif
    held_sum = sum;
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_eq({tag, "_hold_sum"}, 32'(sum), 32'(held_sum));
        check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_retire_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_retire_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_eq({tag, "_idle_sum"}, 32'(sum), 32'(held_sum));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           seen;
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #23;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_add(16'h1234, 16'h4321, 1'b0, 0, "d1234");
    do_add(16'hFFFF, 16'h0001, 1'b0, 0, "dffff");
    do_add(16'h0000, 16'h0000, 1'b1, 0, "dcin");
    do_add(16'h7FFF, 16'h0001, 1'b0, 0, "dovf1");
    do_add(16'h8000, 16'h8000, 1'b0, 0, "dovf2");
    do_add(16'hA5A5, 16'h5A5A, 1'b1, 3, "dhold");

    // Abort at idx = 2: no result pulse follows.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("clr_in_ready", 32'(in_ready), 32'd1);
    check_eq("clr_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < NIB + 2; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("clr_no_valid", 32'(seen), 32'd0);
    do_add(16'h0F0F, 16'h00F1, 1'b0, 0, "dpostclr");

    // clr beats a simultaneous accept.
    clr = 1'b1; in_valid = 1'b1; a = 16'h0101; b = 16'h0101;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check_eq("clr_accept_busy", 32'(busy), 32'd0);
    check_eq("clr_accept_sum", 32'(sum), 32'h1000);

    // Asynchronous reset mid-RUN.
    a = 16'hBEEF; b = 16'h1234; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_sum", 32'(sum), 32'd0);
    check_eq("arst_cout", 32'(cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < NIB + 2; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("arst_no_valid", 32'(seen), 32'd0);
    do_add(16'hBEEF, 16'h1234, 1'b1, 0, "dpostrst");

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      rc = 1'($urandom());
      do_add(ra, rb, rc, int'($urandom_range(0, 2)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
